fft_stage_ctrl: RTL and testbench
=================================

FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, number of butterfly stages per frame (1..8).
REQ-002 SHALL have parameter MAC_LAT, default 2, MAC result latency in cycles (1..4).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  frame present in bank 0.
REQ-006 SHALL have port in_ready  output  1  controller can accept a frame.
REQ-007 SHALL have port out_valid  output  1  transformed frame available.
REQ-008 SHALL have port out_ready  input  1  consumer takes the frame.
REQ-009 SHALL have port abort  input  1  synchronous flush.
REQ-010 SHALL have port mac_sel  output  2  operand/weight mux select (phase) driven to all four MACs.
REQ-011 SHALL have port issue_en  output  1  MAC operands valid this cycle.
REQ-012 SHALL have port stage_idx  output  3  stage currently issuing.
REQ-013 SHALL have port rd_bank  output  1  ping-pong bank read by MACs.
REQ-014 SHALL have port cap_en  output  1  write MAC results this cycle.
REQ-015 SHALL have port cap_sel  output  2  demux slot (phase) being written.
REQ-016 SHALL have port wr_bank  output  1  bank receiving captured results.
REQ-017 SHALL have port final_bank  output  1  bank holding result while out_valid; constant NUM_STAGES mod 2.
REQ-018 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-019 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE: in_ready=1; in_valid&in_ready -> RUN with stage_idx=0, phase=0, rd_bank=0.
REQ-021 RUN: issue_en=1, mac_sel=phase; phase increments 0,1,2,3 once per cycle; after phase 3 -> DRAIN.
REQ-022 DRAIN: issue_en=0 for exactly MAC_LAT cycles; then, if stage_idx=NUM_STAGES-1 -> DONE, else stage_idx+1, rd_bank toggles, phase=0, -> RUN.
REQ-023 Stage s SHALL read bank s mod 2 and write bank (s+1) mod 2.
REQ-024 Capture path SHALL be a MAC_LAT-deep delay line of {issue_en, mac_sel, wr_bank}; cap_en, cap_sel, wr_bank are its tail, so each issue yields exactly one capture MAC_LAT cycles later.
REQ-025 DONE: out_valid=1 held until out_ready=1; on out_valid&out_ready -> IDLE next cycle.
REQ-026 Latency: first issue_en in cycle 1 after acceptance edge; out_valid first high in cycle NUM_STAGES*(4+MAC_LAT)+1.
REQ-027 Outside RUN, mac_sel=0 and issue_en=0; stage_idx holds its value in DRAIN and DONE.
REQ-028 in_valid outside IDLE SHALL be ignored; no frame is queued.
REQ-029 abort (any state) -> IDLE next cycle, delay line cleared, no cap_en thereafter; abort beats in_valid in IDLE and out_ready in DONE.
REQ-030 Wrap: phase 3->0 and stage_idx NUM_STAGES-1 SHALL never overflow; stage_idx returns to 0 only on new acceptance.

Reset
REQ-031 reset low SHALL asynchronously force IDLE, phase=0, stage_idx=0, rd_bank=0, delay line cleared.
REQ-032 While and after reset: out_valid=0, issue_en=0, cap_en=0, mac_sel=0, cap_sel=0, wr_bank=0, busy=0, in_ready=1.
REQ-033 Reset mid-frame SHALL discard the frame; no capture strobe after release.

Structure
REQ-034 Package fft_ctrl_pkg SHALL hold state enum, NUM_PHASES=4, stage index width (3), phase width (2).
REQ-035 Capture delay line SHALL be sub-module fft_cap_pipe parameterised by MAC_LAT; FSM and counters stay in fft_stage_ctrl.

Verification
REQ-036 Defaults, one frame, out_ready=1: out_valid in cycle 31; 20 issue_en and 20 cap_en cycles; cap_sel sequence 0,1,2,3 repeated; final_bank=1.
REQ-037 MAC_LAT=1, NUM_STAGES=3: rd_bank 0,1,0 per stage; each cap_en 1 cycle after its issue with wr_bank = ~rd_bank; out_valid cycle 16.
REQ-038 out_ready low 10 cycles in DONE: out_valid held, in_ready=0, in_valid ignored; accepted exactly once.
REQ-039 abort in stage 2 phase 1: next cycle IDLE, busy=0, no further cap_en; new frame then completes normally in 31 cycles.
REQ-040 reset asserted mid-DRAIN: outputs at reset values immediately (asynchronously); after release in_ready=1, no stray cap_en.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT stage controller.
//   ctrl_state_e : controller FSM states
//   cap_entry_t  : one slot of the capture delay line {valid, phase, bank}
//   NUM_PHASES   : butterfly phases issued per stage
//   STAGE_W      : stage index width
//   PHASE_W      : phase / mux-select width
package fft_ctrl_pkg;

  localparam int unsigned NUM_PHASES = 4;
  localparam int unsigned STAGE_W    = 3;
  localparam int unsigned PHASE_W    = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } ctrl_state_e;

  typedef struct packed {
    logic               vld;
    logic [PHASE_W-1:0] sel;
    logic               bank;
  } cap_entry_t;

endpackage

// File: rtl/fft_cap_pipe.sv
// Capture delay line: replays each MAC issue as a capture strobe MAC_LAT cycles later.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset, clears every slot
//   flush_i : synchronous clear of every slot (abort)
//   vld_i   : operands issued this cycle
//   sel_i   : phase of the issue
//   bank_i  : bank the results of this issue go to
//   vld_o   : capture strobe (tail of the line)
//   sel_o   : demux slot for the capture
//   bank_o  : bank receiving the capture
module fft_cap_pipe
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned MAC_LAT = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               vld_i,
  input  logic [PHASE_W-1:0] sel_i,
  input  logic               bank_i,
  output logic               vld_o,
  output logic [PHASE_W-1:0] sel_o,
  output logic               bank_o
);

  cap_entry_t pipe_q [MAC_LAT];
  cap_entry_t pipe_d [MAC_LAT];

  always_comb begin
    pipe_d[0].vld  = vld_i;
    pipe_d[0].sel  = sel_i;
    pipe_d[0].bank = bank_i;
    for (int i = 1; i < MAC_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    if (flush_i) begin
      for (int i = 0; i < MAC_LAT; i++) begin
        pipe_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAC_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAC_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign vld_o  = pipe_q[MAC_LAT-1].vld;
  assign sel_o  = pipe_q[MAC_LAT-1].sel;
  assign bank_o = pipe_q[MAC_LAT-1].bank;

endmodule

// File: rtl/fft_stage_ctrl.sv
// FFT stage controller: sequences NUM_STAGES butterfly stages over a ping-pong buffer.
// Each stage issues four phases to the MACs, waits MAC_LAT cycles for results to land,
// then swaps banks. Captures are generated by a delay line mirroring the issues.
//   clk, reset         : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  : frame handshake into bank 0
//   out_valid/out_ready: transformed-frame handshake, result sits in final_bank
//   abort              : synchronous flush back to idle
//   mac_sel, issue_en  : MAC operand phase select and issue strobe
//   stage_idx, rd_bank : stage being issued and the bank it reads
//   cap_en, cap_sel    : result capture strobe and demux slot
//   wr_bank            : bank receiving captured results
//   final_bank         : bank holding the finished frame
//   busy               : controller is not idle
module fft_stage_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned MAC_LAT    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               abort,
  output logic [PHASE_W-1:0] mac_sel,
  output logic               issue_en,
  output logic [STAGE_W-1:0] stage_idx,
  output logic               rd_bank,
  output logic               cap_en,
  output logic [PHASE_W-1:0] cap_sel,
  output logic               wr_bank,
  output logic               final_bank,
  output logic               busy
);

  localparam logic [STAGE_W-1:0] LastStage = STAGE_W'(NUM_STAGES - 1);
  localparam logic [PHASE_W-1:0] LastPhase = PHASE_W'(NUM_PHASES - 1);
  localparam logic [1:0]         DrainLast = 2'(MAC_LAT - 1);

  ctrl_state_e        state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic               rd_bank_q, rd_bank_d;
  logic [1:0]         drain_q, drain_d;
  logic               cap_bank_in;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    stage_d   = stage_q;
    rd_bank_d = rd_bank_q;
    drain_d   = drain_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    issue_en  = 1'b0;
    mac_sel   = '0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d   = StRun;
          stage_d   = '0;
          phase_d   = '0;
          rd_bank_d = 1'b0;
        end
      end
      StRun: begin
        issue_en = 1'b1;
        mac_sel  = phase_q;
        phase_d  = phase_q + 1'b1;
        if (phase_q == LastPhase) begin
          state_d = StDrain;
          phase_d = '0;
          drain_d = '0;
        end
      end
      StDrain: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DrainLast) begin
          drain_d = '0;
          if (stage_q == LastStage) begin
            state_d = StDone;
          end else begin
            state_d   = StRun;
            stage_d   = stage_q + 1'b1;
            rd_bank_d = ~rd_bank_q;
            phase_d   = '0;
          end
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over every handshake; stage index is left alone until the next acceptance.
    if (abort) begin
      state_d   = StIdle;
      phase_d   = '0;
      drain_d   = '0;
      stage_d   = stage_q;
      rd_bank_d = rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      stage_q   <= '0;
      rd_bank_q <= 1'b0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      stage_q   <= stage_d;
      rd_bank_q <= rd_bank_d;
      drain_q   <= drain_d;
    end
  end

  // Idle slots carry bank 0 so wr_bank reads 0 whenever no capture is in flight.
  assign cap_bank_in = issue_en & ~rd_bank_q;

  fft_cap_pipe #(
    .MAC_LAT(MAC_LAT)
  ) u_cap_pipe (
    .clk_i  (clk),
    .rst_ni (reset),
    .flush_i(abort),
    .vld_i  (issue_en),
    .sel_i  (mac_sel),
    .bank_i (cap_bank_in),
    .vld_o  (cap_en),
    .sel_o  (cap_sel),
    .bank_o (wr_bank)
  );

  assign stage_idx  = stage_q;
  assign rd_bank    = rd_bank_q;
  assign final_bank = 1'(NUM_STAGES % 2);
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl: a default instance (5 stages, MAC_LAT 2) and a
// 3-stage / MAC_LAT 1 instance sharing clock and reset.
module tb_fft_stage_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       a_in_valid = 1'b0, a_out_ready = 1'b1, a_abort = 1'b0;
  logic       a_in_ready, a_out_valid, a_issue_en, a_rd_bank, a_cap_en, a_wr_bank;
  logic       a_final_bank, a_busy;
  logic [1:0] a_mac_sel, a_cap_sel;
  logic [2:0] a_stage_idx;

  logic       b_in_valid = 1'b0, b_out_ready = 1'b1, b_abort = 1'b0;
  logic       b_in_ready, b_out_valid, b_issue_en, b_rd_bank, b_cap_en, b_wr_bank;
  logic       b_final_bank, b_busy;
  logic [1:0] b_mac_sel, b_cap_sel;
  logic [2:0] b_stage_idx;

  int checks = 0;
  int errors = 0;

  fft_stage_ctrl u_dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .abort(a_abort),
    .mac_sel(a_mac_sel), .issue_en(a_issue_en), .stage_idx(a_stage_idx),
    .rd_bank(a_rd_bank), .cap_en(a_cap_en), .cap_sel(a_cap_sel), .wr_bank(a_wr_bank),
    .final_bank(a_final_bank), .busy(a_busy)
  );

  fft_stage_ctrl #(.NUM_STAGES(3), .MAC_LAT(1)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .abort(b_abort),
    .mac_sel(b_mac_sel), .issue_en(b_issue_en), .stage_idx(b_stage_idx),
    .rd_bank(b_rd_bank), .cap_en(b_cap_en), .cap_sel(b_cap_sel), .wr_bank(b_wr_bank),
    .final_bank(b_final_bank), .busy(b_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reset-value checks on instance A.
  task automatic check_a_reset_vals(input string pfx);
    check_eq({pfx, "_out_valid"}, a_out_valid, 0);
    check_eq({pfx, "_issue_en"}, a_issue_en, 0);
    check_eq({pfx, "_cap_en"}, a_cap_en, 0);
    check_eq({pfx, "_mac_sel"}, a_mac_sel, 0);
    check_eq({pfx, "_cap_sel"}, a_cap_sel, 0);
    check_eq({pfx, "_wr_bank"}, a_wr_bank, 0);
    check_eq({pfx, "_busy"}, a_busy, 0);
    check_eq({pfx, "_in_ready"}, a_in_ready, 1);
    check_eq({pfx, "_stage_idx"}, a_stage_idx, 0);
    check_eq({pfx, "_rd_bank"}, a_rd_bank, 0);
  endtask

  // One full frame on A with out_ready high: 4 issues per stage, captures in the same
  // order two cycles later, out_valid in cycle 5*(4+2)+1 = 31.
  task automatic run_a_frame(input string pfx);
    int n_iss, n_cap, done_cyc, first_iss;
    n_iss = 0; n_cap = 0; done_cyc = -1; first_iss = -1;
    @(negedge clk);
    check_eq({pfx, "_in_ready"}, a_in_ready, 1);
    a_in_valid = 1'b1;
    a_out_ready = 1'b1;
    for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      if (a_issue_en) begin
        if (first_iss < 0) first_iss = cyc;
        check_eq({pfx, "_mac_sel"}, a_mac_sel, n_iss % 4);
        check_eq({pfx, "_stage_idx"}, a_stage_idx, n_iss / 4);
        check_eq({pfx, "_rd_bank"}, a_rd_bank, (n_iss / 4) % 2);
        n_iss++;
      end
      if (a_cap_en) begin
        check_eq({pfx, "_cap_sel"}, a_cap_sel, n_cap % 4);
        check_eq({pfx, "_wr_bank"}, a_wr_bank, (n_cap / 4 + 1) % 2);
        n_cap++;
      end
      if (a_out_valid) done_cyc = cyc;
    end
    check_eq({pfx, "_first_issue_cycle"}, first_iss, 1);
    check_eq({pfx, "_out_valid_cycle"}, done_cyc, 31);
    check_eq({pfx, "_issue_count"}, n_iss, 20);
    check_eq({pfx, "_cap_count"}, n_cap, 20);
    check_eq({pfx, "_final_bank"}, a_final_bank, 1);
    check_eq({pfx, "_done_stage_idx"}, a_stage_idx, 4);
    @(negedge clk);
    check_eq({pfx, "_after_out_valid"}, a_out_valid, 0);
    check_eq({pfx, "_after_in_ready"}, a_in_ready, 1);
    check_eq({pfx, "_after_busy"}, a_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int done_cyc, nb, n_cap;
    logic prev_iss, prev_rd;
    logic [1:0] prev_sel;

    // Power-on reset.
    #1 reset = 1'b0;
    @(negedge clk);
    check_a_reset_vals("por");
    check_eq("por_b_in_ready", b_in_ready, 1);
    check_eq("por_b_cap_en", b_cap_en, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_a_reset_vals("post_por");

    // Default frame.
    run_a_frame("frame1");

    // Instance B: 3 stages, MAC_LAT 1, out_valid in cycle 3*5+1 = 16.
    @(negedge clk);
    b_in_valid = 1'b1;
    done_cyc = -1; nb = 0; prev_iss = 1'b0; prev_sel = '0; prev_rd = 1'b0;
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      b_in_valid = 1'b0;
      check_eq("b_cap_follows_issue", b_cap_en, prev_iss);
      if (prev_iss) begin
        check_eq("b_cap_sel", b_cap_sel, prev_sel);
        check_eq("b_wr_bank", b_wr_bank, prev_rd ? 0 : 1);
      end
      if (b_issue_en) begin
        check_eq("b_rd_bank", b_rd_bank, (nb / 4) % 2);
        check_eq("b_mac_sel", b_mac_sel, nb % 4);
        nb++;
      end
      prev_iss = b_issue_en; prev_sel = b_mac_sel; prev_rd = b_rd_bank;
      if (b_out_valid) done_cyc = cyc;
    end
    check_eq("b_out_valid_cycle", done_cyc, 16);
    check_eq("b_issue_count", nb, 12);
    check_eq("b_final_bank", b_final_bank, 1);

    // Hold in DONE with out_ready low; in_valid must be ignored.
    @(negedge clk);
    a_in_valid = 1'b1;
    a_out_ready = 1'b0;
    done_cyc = -1;
    for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      if (a_out_valid) done_cyc = cyc;
    end
    check_eq("hold_out_valid_cycle", done_cyc, 31);
    a_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("hold_out_valid", a_out_valid, 1);
      check_eq("hold_in_ready", a_in_ready, 0);
      check_eq("hold_busy", a_busy, 1);
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    check_eq("hold_release_out_valid", a_out_valid, 0);
    check_eq("hold_release_in_ready", a_in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("hold_no_requeue_busy", a_busy, 0);
    end

    // Abort in stage 2, phase 1 (cycle 2*6+2 = 14).
    @(negedge clk);
    a_in_valid = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
    end
    check_eq("abort_pre_stage", a_stage_idx, 2);
    check_eq("abort_pre_phase", a_mac_sel, 1);
    check_eq("abort_pre_issue", a_issue_en, 1);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    check_eq("abort_busy", a_busy, 0);
    check_eq("abort_in_ready", a_in_ready, 1);
    check_eq("abort_issue_en", a_issue_en, 0);
    n_cap = 0;
    for (int i = 0; i < 8; i++) begin
      if (a_cap_en) n_cap++;
      @(negedge clk);
    end
    check_eq("abort_no_cap", n_cap, 0);
    check_eq("abort_stays_idle", a_busy, 0);
    // Abort beats in_valid in IDLE.
    a_abort = 1'b1;
    a_in_valid = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    a_in_valid = 1'b0;
    check_eq("abort_vs_in_valid_busy", a_busy, 0);
    run_a_frame("post_abort");

    // Asynchronous reset during stage 0 drain (cycle 5, capture of phase 2 in flight).
    @(negedge clk);
    a_in_valid = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
    end
    check_eq("rst_pre_issue", a_issue_en, 0);
    check_eq("rst_pre_cap_en", a_cap_en, 1);
    check_eq("rst_pre_busy", a_busy, 1);
    #2 reset = 1'b0;
    #1;
    check_a_reset_vals("rst_async");
    @(negedge clk);
    reset = 1'b1;
    n_cap = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_cap_en) n_cap++;
      check_eq("rst_after_in_ready", a_in_ready, 1);
    end
    check_eq("rst_no_stray_cap", n_cap, 0);
    run_a_frame("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
